uart_key_rx: RTL and testbench

- Receives 8N1 serial bytes on the board rx232 pin and decodes them into the 5-bit keypad code space already used by the keypad scanner.
- This gives the video block a remote keypad over RS-232.
- Also exposes raw received bytes plus valid and framing-error strobes for future command parsing.
- Sits in blaster_chip on the 48 MHz clk domain, in parallel with the keypad scanner. The two key outputs are OR-merged upstream.

---
 rtl/blaster_pkg.sv | 48 ++++
 rtl/uart_rx_core.sv | 155 +++++++++++++++
 rtl/uart_key_rx.sv | 84 ++++++++
 tb/tb_uart_key_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/blaster_pkg.sv
// -----------------------------------------------------------------------------
// blaster_pkg
// Shared definitions for the blaster_chip keypad path.
//   - Keypad code space shared by the matrix scanner and the serial keypad
//     receiver (KEY_NONE means "no key pressed").
//   - State encoding of the serial receiver FSM.
//   - key_decode(): maps an ASCII byte onto the keypad code space.
// -----------------------------------------------------------------------------
package blaster_pkg;

    localparam logic [4:0] KEY_NONE = 5'h00;
    localparam logic [4:0] KEY_0    = 5'h10;
    localparam logic [4:0] KEY_1    = 5'h11;
    localparam logic [4:0] KEY_2    = 5'h12;
    localparam logic [4:0] KEY_3    = 5'h13;
    localparam logic [4:0] KEY_4    = 5'h14;
    localparam logic [4:0] KEY_5    = 5'h15;
    localparam logic [4:0] KEY_6    = 5'h16;
    localparam logic [4:0] KEY_7    = 5'h17;
    localparam logic [4:0] KEY_8    = 5'h18;
    localparam logic [4:0] KEY_9    = 5'h19;
    localparam logic [4:0] KEY_STAR = 5'h1A;
    localparam logic [4:0] KEY_HASH = 5'h1B;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Returns {hit, code}. hit=0 means the byte is not a keypad character.
    function automatic logic [5:0] key_decode(input logic [7:0] b);
        logic [5:0] r;
        r = {1'b0, KEY_NONE};
        if (b >= 8'h30 && b <= 8'h39) begin
            // For '0'..'9' the low nibble is already the digit value.
            r = {1'b1, KEY_0 + {1'b0, b[3:0]}};
        end else if (b == 8'h2A) begin
            r = {1'b1, KEY_STAR};
        end else if (b == 8'h23) begin
            r = {1'b1, KEY_HASH};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 serial receiver: synchronises the raw line, finds the start bit,
// samples each bit near its centre and emits one-cycle strobes.
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   rx232     in   asynchronous serial line, idle high
//   rx_data   out  last correctly framed byte (held until the next one)
//   rx_valid  out  one-cycle strobe per correctly framed byte
//   frame_err out  one-cycle strobe when the stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx_core
    import blaster_pkg::*;
#(
    parameter int CLK_HZ = 48_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx232,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int DIV_RAW = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int DIV     = (DIV_RAW < 8) ? 8 : DIV_RAW;
    localparam int HALF    = DIV / 2;
    localparam int TW      = $clog2(DIV);

    localparam logic [TW-1:0] TIMER_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] TIMER_FULL = TW'(DIV - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            prev_q, prev_d;
    rx_state_e       state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;

    logic            line;
    logic            fall;
    logic            tick;

    assign line = sync2_q;
    assign fall = prev_q & ~sync2_q;
    assign tick = (timer_q == '0);

    always_comb begin
        sync1_d     = rx232;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        // Timed states count down until the next sample point.
        if ((state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) && !tick) begin
            timer_d = timer_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    timer_d = TIMER_HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!line) begin
                        timer_d = TIMER_FULL;
                        idx_d   = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        // Start bit gone by mid-bit: a glitch, not a frame.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d[idx_q] = line;
                    timer_d        = TIMER_FULL;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (line) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Line held low (break): wait for idle before hunting again.
                if (line) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Synchroniser presets to idle so reset never fakes a start edge.
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_key_rx.sv
// -----------------------------------------------------------------------------
// uart_key_rx
// Remote keypad over RS-232: receives 8N1 bytes and turns '0'..'9', '*', '#'
// into keypad codes held for HOLD_CYCLES clocks, like a key press.
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   rx232     in   asynchronous serial line, idle high
//   rx_data   out  last correctly framed byte
//   rx_valid  out  one-cycle strobe per correctly framed byte
//   frame_err out  one-cycle strobe on a bad stop bit
//   key       out  decoded key code, KEY_NONE when no key is held
// -----------------------------------------------------------------------------
module uart_key_rx
    import blaster_pkg::*;
#(
    parameter int CLK_HZ      = 48_000_000,
    parameter int BAUD        = 115_200,
    parameter int HOLD_CYCLES = 4_800_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx232,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [4:0] key
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [7:0]    core_data;
    logic          core_valid;
    logic [5:0]    decoded;
    logic [4:0]    key_q, key_d;
    logic [HW-1:0] hold_q, hold_d;

    uart_rx_core #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx232     (rx232),
        .rx_data   (core_data),
        .rx_valid  (core_valid),
        .frame_err (frame_err)
    );

    assign decoded = key_decode(core_data);

    always_comb begin
        key_d  = key_q;
        hold_d = hold_q;
        if (key_q != KEY_NONE) begin
            if (hold_q == '0) begin
                key_d = KEY_NONE;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
        // A fresh key byte overrides the running hold with no gap cycle.
        if (core_valid && decoded[5]) begin
            key_d  = decoded[4:0];
            hold_d = HOLD_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_q  <= KEY_NONE;
            hold_q <= '0;
        end else begin
            key_q  <= key_d;
            hold_q <= hold_d;
        end
    end

    assign rx_data  = core_data;
    assign rx_valid = core_valid;
    assign key      = key_q;

endmodule

// File: tb/tb_uart_key_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_key_rx
// Directed stimulus with a behavioural expectation model: the bench keeps a
// queue of the strobes each transmitted frame must produce and a model of the
// key hold window, and compares every cycle.
// -----------------------------------------------------------------------------
module tb_uart_key_rx;

    localparam int BIT  = 16;
    localparam int HOLD = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx232 = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [4:0] key;

    always #5 clk = ~clk;

    uart_key_rx #(
        .CLK_HZ      (48_000_000),
        .BAUD        (3_000_000),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx232     (rx232),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .key       (key)
    );

    typedef struct packed {
        logic       is_fe;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         fails  = 0;
    int         cycle  = 0;
    logic       rst_seen = 1'b0;
    int         model_rem = 0;
    logic [4:0] model_key = 5'h00;
    logic       prev_valid = 1'b0;
    logic       prev_fe = 1'b0;
    logic       watch_latency = 1'b0;
    int         start_cycle = 0;
    int         first_valid_cycle = -1;

    // Keypad meaning of an ASCII byte; -1 when it is not a key.
    function automatic int expect_code(input logic [7:0] b);
        if (b >= 8'd48 && b <= 8'd57) return 16 + int'(b) - 48;
        if (b == 8'd42) return 26;
        if (b == 8'd35) return 27;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk) begin
        rst_seen <= ~reset_n;
        cycle    <= cycle + 1;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int code;
        if (rst_seen) begin
            model_rem = 0;
            check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
            check("reset frame_err", {31'd0, frame_err}, 32'd0);
            check("reset rx_data", {24'd0, rx_data}, 32'd0);
        end
        check("key", {27'd0, key}, (model_rem > 0) ? {27'd0, model_key} : 32'd0);
        if (model_rem > 0) model_rem--;

        if (rx_valid) begin
            checks++;
            if (frame_err || prev_valid) begin
                fails++;
                $display("FAIL strobe shape: rx_valid=%0b frame_err=%0b prev_valid=%0b", rx_valid, frame_err, prev_valid);
            end
            if (watch_latency && first_valid_cycle < 0) first_valid_cycle = cycle;
            checks++;
            if (exp_q.size() == 0 || exp_q[0].is_fe) begin
                fails++;
                $display("FAIL rx_valid: got unexpected strobe data %0h expected none", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_q[0].data});
                code = expect_code(exp_q[0].data);
                if (code >= 0) begin
                    model_key = 5'(code);
                    model_rem = HOLD;
                end
                void'(exp_q.pop_front());
            end
        end
        if (frame_err) begin
            checks++;
            if (prev_fe) begin
                fails++;
                $display("FAIL frame_err width: got 2+ cycles expected 1");
            end
            checks++;
            if (exp_q.size() == 0 || !exp_q[0].is_fe) begin
                fails++;
                $display("FAIL frame_err: got unexpected strobe expected none");
            end else begin
                void'(exp_q.pop_front());
            end
        end
        prev_valid = rx_valid;
        prev_fe    = frame_err;
    end

    task automatic drive_bit(input logic v);
        rx232 = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
        send_frame(b, 1'b1);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle key", {27'd0, key}, 32'h00);
        check("idle rx_data", {24'd0, rx_data}, 32'h00);

        // '5': latency and full hold window.
        exp_q.push_back({1'b0, 8'h35});
        start_cycle   = cycle;
        watch_latency = 1'b1;
        send_frame(8'h35, 1'b1);
        watch_latency = 1'b0;
        lat = first_valid_cycle - start_cycle;
        checks++;
        if (first_valid_cycle < 0 || lat < 155 || lat > 157) begin
            fails++;
            $display("FAIL latency: got %0d cycles expected 155..157", lat);
        end
        check("key after 5", {27'd0, key}, 32'h15);
        repeat (100) @(negedge clk);
        check("key expired", {27'd0, key}, 32'h00);

        // '*' then '#' back to back.
        send_good(8'h2A);
        send_good(8'h23);
        check("key after #", {27'd0, key}, 32'h1B);
        repeat (120) @(negedge clk);

        // 'A' is not a key.
        send_good(8'h41);
        check("rx_data A", {24'd0, rx_data}, 32'h41);
        check("key after A", {27'd0, key}, 32'h00);
        repeat (20) @(negedge clk);

        // 0x37 with a low stop, 40 cycles of break, then '1'.
        exp_q.push_back({1'b1, 8'h00});
        send_frame(8'h37, 1'b0);
        rx232 = 1'b0;
        repeat (24) @(negedge clk);
        rx232 = 1'b1;
        repeat (20) @(negedge clk);
        check("key after break", {27'd0, key}, 32'h00);
        send_good(8'h31);
        check("key after 1", {27'd0, key}, 32'h11);
        repeat (120) @(negedge clk);

        // Short glitch, then '0'.
        rx232 = 1'b0;
        repeat (4) @(negedge clk);
        rx232 = 1'b1;
        repeat (30) @(negedge clk);
        send_good(8'h30);
        check("key after 0", {27'd0, key}, 32'h10);
        repeat (120) @(negedge clk);

        // '2' held, then reset in the middle of 0x39 until its stop bit.
        send_good(8'h32);
        fork
            send_frame(8'h39, 1'b1);
            begin
                repeat (BIT * 4 + 8) @(negedge clk);
                check("key before reset", {27'd0, key}, 32'h12);
                reset_n = 1'b0;
                repeat (BIT * 5) @(negedge clk);
                reset_n = 1'b1;
            end
        join
        repeat (40) @(negedge clk);
        check("key after reset", {27'd0, key}, 32'h00);
        send_good(8'h33);
        check("key after 3", {27'd0, key}, 32'h13);
        repeat (120) @(negedge clk);

        check("pending strobes", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
